// File: rtl/string_hw_avalon_host_if.sv
// Command/response handshake and Avalon-MM bus bundle for the string accelerator host.
// The master modport is the host's view; the slave modport is the client/fabric side.
interface string_hw_avalon_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_index;
    logic [2:0]  cmd_length;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_timeout;
    logic [2:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_index, cmd_length, rsp_ready,
               avm_readdata, avm_waitrequest,
        output cmd_ready, rsp_valid, rsp_result, rsp_timeout,
               avm_address, avm_chipselect, avm_write, avm_read, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_index, cmd_length, rsp_ready,
               avm_readdata, avm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_result, rsp_timeout,
               avm_address, avm_chipselect, avm_write, avm_read, avm_writedata
    );
endinterface

// File: rtl/string_hw_avalon_host.sv
// Avalon-MM master sequencing one accelerator job per command:
// write A, B, Control(go), poll Status, read Result, clear go, then respond.
module string_hw_avalon_host #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_LIMIT   = 1024
) (
    input logic                     clk,
    input logic                     reset,
    string_hw_avalon_host_if.master bus
);
    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_CTL, RD_STAT, WAIT_STAT, RD_RES, WAIT_RES, CLR_GO, RESP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [2:0]    index_q, index_d;
    logic [2:0]    length_q, length_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [2:0]    lat_q, lat_d;
    logic [31:0]   rsp_result_q, rsp_result_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [2:0]    avm_address_q, avm_address_d;
    logic [31:0]   avm_writedata_q, avm_writedata_d;
    logic          avm_write_q, avm_write_d;
    logic          avm_read_q, avm_read_d;
    logic          accept;
    logic          capture;
    logic          done;
    logic [31:0]   ctl_go;
    logic [31:0]   ctl_clr;

    assign accept  = (avm_write_q | avm_read_q) & ~bus.avm_waitrequest;
    assign capture = (lat_q == '0);
    assign done    = bus.avm_readdata[0];
    assign ctl_go  = {25'd0, length_q, index_q, 1'b1};
    assign ctl_clr = {25'd0, length_q, index_q, 1'b0};

    // Each accept loads the next transaction in the same cycle, so strobes run back-to-back.
    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        index_d         = index_q;
        length_d        = length_q;
        poll_d          = poll_q;
        lat_d           = lat_q;
        rsp_result_d    = rsp_result_q;
        rsp_timeout_d   = rsp_timeout_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        avm_write_d     = avm_write_q;
        avm_read_d      = avm_read_q;

        if (accept) begin
            avm_write_d = 1'b0;
            avm_read_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    a_d             = bus.cmd_a;
                    b_d             = bus.cmd_b;
                    index_d         = bus.cmd_index;
                    length_d        = bus.cmd_length;
                    poll_d          = '0;
                    avm_write_d     = 1'b1;
                    avm_address_d   = 3'd0;
                    avm_writedata_d = bus.cmd_a;
                    state_d         = WR_A;
                end
            end
            WR_A: begin
                if (accept) begin
                    avm_write_d     = 1'b1;
                    avm_address_d   = 3'd1;
                    avm_writedata_d = b_q;
                    state_d         = WR_B;
                end
            end
            WR_B: begin
                if (accept) begin
                    avm_write_d     = 1'b1;
                    avm_address_d   = 3'd2;
                    avm_writedata_d = ctl_go;
                    state_d         = WR_CTL;
                end
            end
            WR_CTL: begin
                if (accept) begin
                    avm_read_d      = 1'b1;
                    avm_address_d   = 3'd2;
                    avm_writedata_d = '0;
                    state_d         = RD_STAT;
                end
            end
            RD_STAT: begin
                if (accept) begin
                    poll_d  = poll_q + 1'b1;
                    lat_d   = LAT_LOAD;
                    state_d = WAIT_STAT;
                end
            end
            WAIT_STAT: begin
                if (!capture) begin
                    lat_d = lat_q - 1'b1;
                end else if (done) begin
                    avm_read_d    = 1'b1;
                    avm_address_d = 3'd3;
                    state_d       = RD_RES;
                end else if (poll_q == POLL_MAX) begin
                    rsp_timeout_d   = 1'b1;
                    rsp_result_d    = '0;
                    avm_write_d     = 1'b1;
                    avm_address_d   = 3'd2;
                    avm_writedata_d = ctl_clr;
                    state_d         = CLR_GO;
                end else begin
                    avm_read_d    = 1'b1;
                    avm_address_d = 3'd2;
                    state_d       = RD_STAT;
                end
            end
            RD_RES: begin
                if (accept) begin
                    lat_d   = LAT_LOAD;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (!capture) begin
                    lat_d = lat_q - 1'b1;
                end else begin
                    rsp_result_d    = bus.avm_readdata;
                    avm_write_d     = 1'b1;
                    avm_address_d   = 3'd2;
                    avm_writedata_d = ctl_clr;
                    state_d         = CLR_GO;
                end
            end
            CLR_GO: begin
                if (accept) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            index_q         <= '0;
            length_q        <= '0;
            poll_q          <= '0;
            lat_q           <= '0;
            rsp_result_q    <= '0;
            rsp_timeout_q   <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_write_q     <= 1'b0;
            avm_read_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            index_q         <= index_d;
            length_q        <= length_d;
            poll_q          <= poll_d;
            lat_q           <= lat_d;
            rsp_result_q    <= rsp_result_d;
            rsp_timeout_q   <= rsp_timeout_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            avm_write_q     <= avm_write_d;
            avm_read_q      <= avm_read_d;
        end
    end

    assign bus.cmd_ready      = (state_q == IDLE);
    assign bus.rsp_valid      = (state_q == RESP);
    assign bus.rsp_result     = rsp_result_q;
    assign bus.rsp_timeout    = rsp_timeout_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_writedata  = avm_writedata_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_read       = avm_read_q;
    assign bus.avm_chipselect = avm_write_q | avm_read_q;
endmodule

// File: tb/tb_string_hw_avalon_host.sv
// Bench for string_hw_avalon_host: two instances (read latency 1 and 3, poll limit 4)
// driven by a shared accelerator-slave model and checked against a transaction-level model.
module tb_string_hw_avalon_host;
    localparam int PL = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    string_hw_avalon_host_if if0 ();
    string_hw_avalon_host_if if1 ();

    string_hw_avalon_host #(.READ_LATENCY(1), .POLL_LIMIT(PL)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    string_hw_avalon_host #(.READ_LATENCY(3), .POLL_LIMIT(PL)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    logic        sel;
    logic        cmd_valid;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_index, cmd_length;
    logic        rsp_ready;
    logic [31:0] readdata;
    logic        waitreq;

    assign if0.cmd_valid = cmd_valid & ~sel;
    assign if1.cmd_valid = cmd_valid & sel;
    assign if0.cmd_a = cmd_a;            assign if1.cmd_a = cmd_a;
    assign if0.cmd_b = cmd_b;            assign if1.cmd_b = cmd_b;
    assign if0.cmd_index = cmd_index;    assign if1.cmd_index = cmd_index;
    assign if0.cmd_length = cmd_length;  assign if1.cmd_length = cmd_length;
    assign if0.rsp_ready = rsp_ready & ~sel;
    assign if1.rsp_ready = rsp_ready & sel;
    assign if0.avm_readdata = readdata;  assign if1.avm_readdata = readdata;
    assign if0.avm_waitrequest = waitreq; assign if1.avm_waitrequest = waitreq;

    logic        o_cmd_ready, o_rsp_valid, o_rsp_timeout, o_cs, o_wr, o_rd;
    logic [31:0] o_rsp_result, o_wdata;
    logic [2:0]  o_addr;
    assign o_cmd_ready   = sel ? if1.cmd_ready      : if0.cmd_ready;
    assign o_rsp_valid   = sel ? if1.rsp_valid      : if0.rsp_valid;
    assign o_rsp_result  = sel ? if1.rsp_result     : if0.rsp_result;
    assign o_rsp_timeout = sel ? if1.rsp_timeout    : if0.rsp_timeout;
    assign o_cs          = sel ? if1.avm_chipselect : if0.avm_chipselect;
    assign o_wr          = sel ? if1.avm_write      : if0.avm_write;
    assign o_rd          = sel ? if1.avm_read       : if0.avm_read;
    assign o_addr        = sel ? if1.avm_address    : if0.avm_address;
    assign o_wdata       = sel ? if1.avm_writedata  : if0.avm_writedata;

    typedef struct {
        bit          inst;
        logic [31:0] a, b;
        logic [2:0]  idx, len;
        int          done_poll;   // status read that first reports done; 0 = never
        logic [31:0] result;
        int          wait_n;      // waitrequest cycles per transaction
        bit          stale;       // junk (bit0=1) readdata outside the sampled cycle
        int          rsp_delay;
        bit          busy;        // extra cmd_valid pulse while busy
        bit          early;       // rsp_ready held high before rsp_valid
        logic [31:0] exp_res;
        bit          exp_to;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_vec  = -1;

    // slave model state
    int          wait_n, done_poll, wcnt, rd_left, stat_reads;
    logic [31:0] res_val, rd_val;
    bit          stale, bus_ok;
    logic [35:0] cur;
    logic [35:0] log_q[$];
    logic [35:0] exp_q[$];
    int          exp_lat;
    vec_t        tab[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", cur_vec, name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl(input logic [2:0] len, input logic [2:0] idx, input int go);
        return 32'(go + int'(idx) * 2 + int'(len) * 16);
    endfunction

    function automatic bit done_in_time(input vec_t v);
        return v.done_poll != 0 && v.done_poll <= PL;
    endfunction

    function automatic vec_t mk(input bit inst, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] idx, input logic [2:0] len, input int dp,
                                input logic [31:0] result, input int wn, input bit st,
                                input int dly, input bit busy, input bit early,
                                input logic [31:0] exp_res, input bit exp_to);
        vec_t v;
        v.inst = inst; v.a = a; v.b = b; v.idx = idx; v.len = len; v.done_poll = dp;
        v.result = result; v.wait_n = wn; v.stale = st; v.rsp_delay = dly; v.busy = busy;
        v.early = early; v.exp_res = exp_res; v.exp_to = exp_to;
        return v;
    endfunction

    // Transaction-level expectation: what the slave must see, in order, and the cycle count.
    task automatic build_exp(input vec_t v);
        bit d;
        int npoll;
        d = done_in_time(v);
        npoll = d ? v.done_poll : PL;
        exp_q.delete();
        exp_q.push_back({1'b1, 3'd0, v.a});
        exp_q.push_back({1'b1, 3'd1, v.b});
        exp_q.push_back({1'b1, 3'd2, ctl(v.len, v.idx, 1)});
        for (int i = 0; i < npoll; i++) exp_q.push_back({1'b0, 3'd2, 32'h0});
        if (d) exp_q.push_back({1'b0, 3'd3, 32'h0});
        exp_q.push_back({1'b1, 3'd2, ctl(v.len, v.idx, 0)});
        exp_lat = 1 + exp_q.size() * (v.wait_n + 1) + (npoll + (d ? 1 : 0)) * (v.inst ? 3 : 1);
    endtask

    task automatic slave_step();
        logic [35:0] now;
        if (rd_left > 0) begin
            rd_left--;
            readdata = (rd_left == 0) ? rd_val : (stale ? 32'hDEAD_BEEF : 32'h0);
        end else begin
            readdata = stale ? 32'hDEAD_BEEF : 32'h0;
        end
        if (o_rd && o_wr) bus_ok = 1'b0;
        if (o_rd || o_wr) begin
            now = {o_wr, o_addr, o_wr ? o_wdata : 32'h0};
            if (!o_cs) bus_ok = 1'b0;
            if (wcnt == 0) cur = now;
            else if (now !== cur) bus_ok = 1'b0;
            if (wcnt < wait_n) begin
                waitreq = 1'b1;
                wcnt++;
            end else begin
                waitreq = 1'b0;
                wcnt = 0;
                log_q.push_back(cur);
                if (!cur[35]) begin
                    rd_left = sel ? 3 : 1;
                    if (cur[34:32] == 3'd2) begin
                        stat_reads++;
                        rd_val = (done_poll != 0 && stat_reads >= done_poll) ? 32'h0000_0001 : 32'hFFFF_FFFE;
                    end else if (cur[34:32] == 3'd3) begin
                        rd_val = res_val;
                    end else begin
                        rd_val = 32'h0;
                    end
                end
            end
        end else begin
            if (wcnt != 0) bus_ok = 1'b0;
            wcnt = 0;
            waitreq = 1'b0;
        end
    endtask

    task automatic setup(input vec_t v);
        sel = v.inst; wait_n = v.wait_n; done_poll = v.done_poll; res_val = v.result;
        stale = v.stale; stat_reads = 0; wcnt = 0; rd_left = 0; bus_ok = 1'b1;
        log_q.delete();
    endtask

    task automatic start_cmd(input vec_t v);
        @(negedge clk);
        slave_step();
        check("cmd_ready_idle", 64'(o_cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_index = v.idx; cmd_length = v.len;
        rsp_ready = v.early;
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
        check("rst_rsp_result", 64'(o_rsp_result), 64'(0));
        check("rst_rsp_timeout", 64'(o_rsp_timeout), 64'(0));
        check("rst_read", 64'(o_rd), 64'(0));
        check("rst_write", 64'(o_wr), 64'(0));
        check("rst_chipselect", 64'(o_cs), 64'(0));
        check("rst_address", 64'(o_addr), 64'(0));
        check("rst_writedata", 64'(o_wdata), 64'(0));
    endtask

    task automatic run_cmd(input vec_t v);
        int lat;
        bit got, rsp_ok;
        logic [31:0] r0;
        logic t0;
        build_exp(v);
        setup(v);
        start_cmd(v);
        lat = 0; got = 1'b0;
        while (!got && lat < 3000) begin
            @(negedge clk);
            lat++;
            cmd_valid = 1'b0;
            if (v.busy && lat == 2) begin
                cmd_valid = 1'b1; cmd_a = ~v.a; cmd_b = ~v.b;
            end
            if (lat == 1) check("cmd_ready_drop", 64'(o_cmd_ready), 64'(0));
            slave_step();
            if (o_rsp_valid) got = 1'b1;
        end
        check("rsp_valid_seen", 64'(got), 64'(1));
        check("latency", 64'(lat), 64'(exp_lat));
        check("rsp_result", 64'(o_rsp_result), 64'(v.exp_res));
        check("rsp_timeout", 64'(o_rsp_timeout), 64'(v.exp_to));
        r0 = o_rsp_result; t0 = o_rsp_timeout; rsp_ok = 1'b1;
        if (!v.early) begin
            for (int i = 0; i < v.rsp_delay; i++) begin
                @(negedge clk);
                slave_step();
                if (!o_rsp_valid || o_rsp_result !== r0 || o_rsp_timeout !== t0 || o_cmd_ready)
                    rsp_ok = 1'b0;
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        slave_step();
        rsp_ready = 1'b0;
        check("rsp_hold", 64'(rsp_ok), 64'(1));
        check("post_cmd_ready", 64'(o_cmd_ready), 64'(1));
        check("post_rsp_valid", 64'(o_rsp_valid), 64'(0));
        check("post_rsp_timeout", 64'(o_rsp_timeout), 64'(0));
        check("post_result_kept", 64'(o_rsp_result), 64'(v.exp_res));
        repeat (4) begin
            @(negedge clk);
            slave_step();
        end
        check("bus_protocol", 64'(bus_ok), 64'(1));
        check("txn_count", 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("txn%0d", i), 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        vec_t v;
        int n_table;
        int waited;
        reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        cmd_index = '0; cmd_length = '0; rsp_ready = 1'b0; readdata = '0; waitreq = 1'b0;
        wait_n = 0; done_poll = 0; wcnt = 0; rd_left = 0; stat_reads = 0;
        res_val = '0; rd_val = '0; stale = 1'b0; bus_ok = 1'b1; cur = '0;

        #1;
        check_reset_vals();
        sel = 1'b1; #1;
        check_reset_vals();
        sel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        //             inst a             b             idx   len   done result        wait st dly busy early exp_res       exp_to
        tab.push_back(mk(0, 32'h64636261, 32'h68676665, 3'd2, 3'd4, 3, 32'h11223344, 0, 0, 0, 0, 0, 32'h11223344, 0));
        tab.push_back(mk(0, 32'h64636261, 32'h68676665, 3'd2, 3'd4, 3, 32'h11223344, 3, 0, 0, 0, 0, 32'h11223344, 0));
        tab.push_back(mk(0, 32'h00000001, 32'h00000002, 3'd7, 3'd7, 0, 32'hAAAA5555, 0, 0, 1, 0, 0, 32'h00000000, 1));
        tab.push_back(mk(1, 32'h13579BDF, 32'h2468ACE0, 3'd5, 3'd1, 3, 32'hCAFEF00D, 0, 1, 0, 0, 0, 32'hCAFEF00D, 0));
        tab.push_back(mk(0, 32'hFFFFFFFF, 32'h00000000, 3'd0, 3'd0, 1, 32'h0BADF00D, 0, 0, 5, 1, 0, 32'h0BADF00D, 0));
        tab.push_back(mk(1, 32'h0F0F0F0F, 32'hF0F0F0F0, 3'd3, 3'd6, 0, 32'h77777777, 1, 1, 2, 1, 0, 32'h00000000, 1));
        tab.push_back(mk(1, 32'h89ABCDEF, 32'h01234567, 3'd1, 3'd2, 2, 32'h5A5A1234, 1, 0, 0, 0, 1, 32'h5A5A1234, 0));
        tab.push_back(mk(0, 32'h31323334, 32'h35363738, 3'd4, 3'd3, 5, 32'h99999999, 0, 0, 0, 0, 0, 32'h00000000, 1));
        n_table = tab.size();
        for (int i = 0; i < 12; i++) begin
            v.inst = 1'($urandom_range(0, 1));
            v.a = $urandom; v.b = $urandom;
            v.idx = 3'($urandom_range(0, 7)); v.len = 3'($urandom_range(0, 7));
            v.done_poll = int'($urandom_range(0, 6));
            v.result = $urandom | 32'h1;
            v.wait_n = int'($urandom_range(0, 2));
            v.stale = v.inst ? 1'($urandom_range(0, 1)) : 1'b0;
            v.rsp_delay = int'($urandom_range(0, 3));
            v.busy = 1'($urandom_range(0, 1));
            v.early = 1'($urandom_range(0, 1));
            v.exp_res = done_in_time(v) ? v.result : 32'h0;
            v.exp_to = !done_in_time(v);
            tab.push_back(v);
        end

        for (int i = 0; i < tab.size(); i++) begin
            cur_vec = i;
            run_cmd(tab[i]);
        end

        // Reset while waiting on a status read: outputs clear at once, next command starts clean.
        cur_vec = tab.size();
        run_cmd(tab[3]);
        v = tab[3];
        v.done_poll = 0;
        setup(v);
        start_cmd(v);
        waited = 0;
        while (stat_reads < 1 && waited < 200) begin
            @(negedge clk);
            waited++;
            cmd_valid = 1'b0;
            slave_step();
        end
        check("reach_status_poll", 64'(stat_reads), 64'(1));
        @(negedge clk);
        slave_step();
        #2 reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        waitreq = 1'b0;
        readdata = '0;
        cur_vec = tab.size() + 1;
        run_cmd(tab[3]);
        cur_vec = tab.size() + 2;
        run_cmd(tab[0]);

        if (n_table < 1) $display("note: empty table");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
